// File: rtl/operand_fetch.sv
// Operand-fetch stage: 32x32 register file read, R-type decode and valid/ready
// output register with writeback bypass and refresh of stalled operands.
module operand_fetch #(
    parameter int unsigned NREGS    = 32,
    parameter logic [5:0]  R_OPCODE = 6'b000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [4:0]  control_ALUop,
    output logic        illegal,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam logic [AW-1:0] FN_SLL = 5'b10001;
    localparam logic [AW-1:0] FN_SRL = 5'b10010;
    localparam logic [AW-1:0] FN_SRA = 5'b10101;

    logic [DW-1:0] regs [NREGS];

    logic [AW-1:0] rs_c;
    logic [AW-1:0] rt_c;
    logic [AW-1:0] funct_c;
    logic          legal_c;
    logic          imm_c;
    logic          wb_live_c;
    logic [DW-1:0] rd_rs_c;
    logic [DW-1:0] rd_rt_c;
    logic          accept_c;
    logic          stall_c;

    logic [AW-1:0] lat_rs;
    logic [AW-1:0] lat_rt;
    logic          lat_imm;

    assign in_ready = !out_valid || out_ready;

    // Decode and bypassed register reads for the instruction on the input
    always_comb begin
        rs_c      = instr[25:21];
        rt_c      = instr[20:16];
        funct_c   = instr[4:0];
        legal_c   = (instr[31:26] == R_OPCODE);
        imm_c     = (funct_c == FN_SLL) || (funct_c == FN_SRL) || (funct_c == FN_SRA);
        wb_live_c = wb_en && (wb_addr != '0);
        accept_c  = in_valid && in_ready;
        stall_c   = out_valid && !out_ready;
        rd_rs_c   = '0;
        rd_rt_c   = '0;
        if (rs_c != '0) begin
            rd_rs_c = (wb_live_c && wb_addr == rs_c) ? wb_data : regs[rs_c];
        end
        if (rt_c != '0) begin
            rd_rt_c = (wb_live_c && wb_addr == rt_c) ? wb_data : regs[rt_c];
        end
    end

    // Register file; r0 is never written so it always reads as zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_live_c) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Pipeline register; refresh keeps stalled operands coherent with writeback
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid     <= 1'b0;
            op_a          <= '0;
            op_b          <= '0;
            control_ALUop <= '0;
            illegal       <= 1'b0;
            lat_rs        <= '0;
            lat_rt        <= '0;
            lat_imm       <= 1'b0;
        end else if (accept_c) begin
            out_valid <= 1'b1;
            if (legal_c) begin
                op_a          <= rd_rs_c;
                op_b          <= imm_c ? instr : rd_rt_c;
                control_ALUop <= funct_c;
                illegal       <= 1'b0;
                lat_rs        <= rs_c;
                lat_rt        <= rt_c;
                lat_imm       <= imm_c;
            end else begin
                op_a          <= '0;
                op_b          <= '0;
                control_ALUop <= '0;
                illegal       <= 1'b1;
                lat_rs        <= '0;
                lat_rt        <= '0;
                lat_imm       <= 1'b0;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else if (stall_c && !illegal && wb_live_c) begin
            if (wb_addr == lat_rs) begin
                op_a <= wb_data;
            end
            if (!lat_imm && wb_addr == lat_rt) begin
                op_b <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch: reset, decode, bypass,
// stall/refresh, r0 handling and illegal opcodes.
module tb_operand_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        in_valid;
    logic        in_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  control_ALUop;
    logic        illegal;
    logic        out_valid;
    logic        out_ready;

    int n_cmp = 0;
    int n_err = 0;

    operand_fetch dut (
        .clk(clk), .rst(rst), .instr(instr), .in_valid(in_valid), .in_ready(in_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .op_a(op_a), .op_b(op_b), .control_ALUop(control_ALUop), .illegal(illegal),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] shamt, input logic [4:0] funct);
        return {6'b000000, rs, rt, 5'd0, shamt, 1'b0, funct};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] ins);
        instr    = ins;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
        tick();
        wb_en   = 1'b0;
    endtask

    logic [31:0] ins;

    initial begin
        rst = 1'b0; instr = '0; in_valid = 1'b0; out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Fill the array with nonzero data, put an instruction in flight, then reset
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'hA5A5_0000 | 32'(i));
        accept(mk_r(5'd2, 5'd3, 5'd0, 5'b00000));
        check("pre_rst_op_a", op_a, 32'hA5A5_0002);
        instr = mk_r(5'd4, 5'd5, 5'd0, 5'b00000);
        in_valid = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        in_valid = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_op_a", op_a, 32'd0);
        check("rst_op_b", op_b, 32'd0);
        check("rst_aluop", 32'(control_ALUop), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        tick();
        rst = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("rst_release_out_valid", 32'(out_valid), 32'd0);

        // Every register reads zero after reset
        for (int i = 1; i < 32; i++) begin
            accept(mk_r(5'(i), 5'(i), 5'd0, 5'b00000));
            check($sformatf("rst_reg_a%0d", i), op_a, 32'd0);
            check($sformatf("rst_reg_b%0d", i), op_b, 32'd0);
        end

        // Immediate shift: op_b is the raw instruction word
        write_reg(5'd3, 32'h8000_00F0);
        ins = mk_r(5'd3, 5'd0, 5'd4, 5'b10101);
        accept(ins);
        check("imm_op_a", op_a, 32'h8000_00F0);
        check("imm_op_b", op_b, ins);
        check("imm_aluop", 32'(control_ALUop), 32'h15);
        check("imm_illegal", 32'(illegal), 32'd0);
        check("imm_out_valid", 32'(out_valid), 32'd1);

        // Same-cycle writeback bypass on rt
        instr = mk_r(5'd5, 5'd6, 5'd0, 5'b10011);
        in_valid = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'd7;
        tick();
        in_valid = 1'b0; wb_en = 1'b0;
        check("byp_op_b", op_b, 32'd7);
        check("byp_op_a", op_a, 32'd0);
        check("byp_aluop", 32'(control_ALUop), 32'h13);
        accept(mk_r(5'd6, 5'd3, 5'd0, 5'b00000));
        check("byp_array_r6", op_a, 32'd7);
        check("byp_array_r3", op_b, 32'h8000_00F0);
        tick();
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_hold_op_a", op_a, 32'd7);

        // Stall: hold outputs, refresh rs, then release
        out_ready = 1'b0;
        accept(mk_r(5'd3, 5'd6, 5'd0, 5'b00000));
        check("stall_op_a0", op_a, 32'h8000_00F0);
        instr = mk_r(5'd6, 5'd3, 5'd0, 5'b00001);
        in_valid = 1'b1;
        check("stall_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("stall_hold_op_a", op_a, 32'h8000_00F0);
        check("stall_hold_op_b", op_b, 32'd7);
        check("stall_hold_aluop", 32'(control_ALUop), 32'd0);
        check("stall_hold_valid", 32'(out_valid), 32'd1);
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h1234;
        tick();
        wb_en = 1'b0;
        check("refresh_op_a", op_a, 32'h1234);
        check("refresh_op_b", op_b, 32'd7);
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("release_op_a", op_a, 32'd7);
        check("release_op_b", op_b, 32'h1234);
        check("release_aluop", 32'(control_ALUop), 32'd1);

        // Immediate-shift op_b is never refreshed, rs still is
        out_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        ins = mk_r(5'd4, 5'd3, 5'd2, 5'b10001);
        accept(ins);
        write_reg(5'd3, 32'hDEAD_BEEF);
        check("imm_norefresh_op_b", op_b, ins);
        write_reg(5'd4, 32'h0000_0055);
        check("imm_refresh_op_a", op_a, 32'h0000_0055);
        out_ready = 1'b1;
        tick();

        // r0 ignores writes
        write_reg(5'd0, 32'hFFFF_FFFF);
        accept(mk_r(5'd0, 5'd0, 5'd0, 5'b00000));
        check("r0_op_a", op_a, 32'd0);
        check("r0_op_b", op_b, 32'd0);

        // Illegal opcode
        accept({6'b100011, 5'd3, 5'd6, 16'h1234});
        check("ill_illegal", 32'(illegal), 32'd1);
        check("ill_aluop", 32'(control_ALUop), 32'd0);
        check("ill_op_a", op_a, 32'd0);
        check("ill_op_b", op_b, 32'd0);
        check("ill_out_valid", 32'(out_valid), 32'd1);
        tick();
        check("ill_drain_valid", 32'(out_valid), 32'd0);
        check("ill_drain_hold", 32'(illegal), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
